// File: rtl/deadlock_report_ctrl.sv
// rtl/deadlock_report_ctrl.sv - persistence-filtered deadlock latch with byte-stream report
// Purpose: confirms a deadlock once block has been sampled high for PERSIST
//          consecutive enabled cycles, latches info and timestamp, then streams
//          a report of 0xDE, info and timestamp (LSB first).
// Ports:   clock, reset (synchronous, active-high)
//          enable, block, axis_block_info  - monitor inputs
//          clear                           - re-arm request, honoured in HOLD
//          deadlock, deadlock_info, deadlock_cycle - sticky latched result
//          rpt_valid, rpt_data, rpt_last, rpt_ready - report byte stream
module deadlock_report_ctrl #(
   parameter int INFO_W  = 4,
   parameter int PERSIST = 16,
   parameter int TS_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              block,
   input  logic [INFO_W-1:0] axis_block_info,
   input  logic              clear,
   output logic              deadlock,
   output logic [INFO_W-1:0] deadlock_info,
   output logic [TS_W-1:0]   deadlock_cycle,
   output logic              rpt_valid,
   output logic [7:0]        rpt_data,
   output logic              rpt_last,
   input  logic              rpt_ready
);

   localparam int NBYTES = 2 + TS_W / 8;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int PCNT_W = $clog2(PERSIST + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NBYTES - 1);
   localparam logic [PCNT_W-1:0] PERSIST_M1 = PCNT_W'(PERSIST - 1);

   typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_REPORT, S_HOLD} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [TS_W-1:0]    cycle_cnt;
   logic [PCNT_W-1:0]  pcnt;
   logic [IDX_W-1:0]   byte_idx;
   logic               hit;
   logic               confirm;
   logic               accept;
   logic               rearm;

   assign hit = enable & block;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      confirm   = 1'b0;
      accept    = 1'b0;
      rearm     = 1'b0;
      case (state)
         S_IDLE: begin
            if (hit) begin
               if (PERSIST == 1) begin
                  confirm   = 1'b1;
                  state_nxt = S_REPORT;
               end else begin
                  state_nxt = S_CONFIRM;
               end
            end
         end
         S_CONFIRM: begin
            if (!hit) begin
               state_nxt = S_IDLE;
            end else if (pcnt == PERSIST_M1) begin
               // this sample is the PERSIST-th consecutive one
               confirm   = 1'b1;
               state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            accept = rpt_ready;
            if (rpt_ready && (byte_idx == LAST_IDX)) begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (clear) begin
               rearm     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt      <= '0;
         pcnt           <= '0;
         byte_idx       <= '0;
         deadlock       <= 1'b0;
         deadlock_info  <= '0;
         deadlock_cycle <= '0;
      end else begin
         // timestamp saturates so a very long run never reports a wrapped value
         if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + TS_W'(1);
         end

         if (confirm || rearm) begin
            pcnt <= '0;
         end else if (state == S_IDLE || state == S_CONFIRM) begin
            pcnt <= hit ? pcnt + PCNT_W'(1) : '0;
         end

         if (confirm) begin
            deadlock       <= 1'b1;
            deadlock_info  <= axis_block_info;
            deadlock_cycle <= cycle_cnt;
            byte_idx       <= '0;
         end else if (accept) begin
            byte_idx <= byte_idx + IDX_W'(1);
         end

         // latched info/cycle stay visible after re-arm
         if (rearm) begin
            deadlock <= 1'b0;
         end
      end
   end

   assign rpt_valid = (state == S_REPORT);

   // bytes are selected from registered state only, so they hold under backpressure
   always_comb begin
      rpt_data = 8'h00;
      rpt_last = 1'b0;
      if (rpt_valid) begin
         rpt_last = (byte_idx == LAST_IDX);
         if (byte_idx == IDX_W'(0)) begin
            rpt_data = 8'hDE;
         end else if (byte_idx == IDX_W'(1)) begin
            rpt_data = 8'(deadlock_info);
         end else begin
            for (int i = 0; i < TS_W / 8; i++) begin
               if (byte_idx == IDX_W'(i + 2)) begin
                  rpt_data = deadlock_cycle[i*8 +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// tb/tb_deadlock_report_ctrl.sv - self-checking bench for deadlock_report_ctrl
module tb_deadlock_report_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        block;
   logic [3:0]  axis_info;
   logic        clear;
   logic        rpt_ready;

   logic        a_deadlock, a_valid, a_last;
   logic [3:0]  a_info;
   logic [31:0] a_cycle;
   logic [7:0]  a_data;

   logic        b_deadlock, b_valid, b_last;
   logic [2:0]  b_info;
   logic [7:0]  b_cycle;
   logic [7:0]  b_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   deadlock_report_ctrl u_a (
      .clock(clock), .reset(reset), .enable(enable), .block(block),
      .axis_block_info(axis_info), .clear(clear),
      .deadlock(a_deadlock), .deadlock_info(a_info), .deadlock_cycle(a_cycle),
      .rpt_valid(a_valid), .rpt_data(a_data), .rpt_last(a_last), .rpt_ready(rpt_ready)
   );

   deadlock_report_ctrl #(.INFO_W(3), .PERSIST(1), .TS_W(8)) u_b (
      .clock(clock), .reset(reset), .enable(enable), .block(block),
      .axis_block_info(axis_info[2:0]), .clear(clear),
      .deadlock(b_deadlock), .deadlock_info(b_info), .deadlock_cycle(b_cycle),
      .rpt_valid(b_valid), .rpt_data(b_data), .rpt_last(b_last), .rpt_ready(rpt_ready)
   );

   // reference model: index 0 = defaults, index 1 = PERSIST 1 / TS_W 8 / INFO_W 3
   int          pers  [2] = '{16, 1};
   int          tsb   [2] = '{4, 1};
   longint      cmax  [2] = '{64'hFFFF_FFFF, 64'd255};
   int          imask [2] = '{15, 7};
   longint      m_cnt [2];
   longint      m_ts  [2];
   int          m_run [2];
   bit          m_hold[2];
   bit          m_dl  [2];
   int          m_info[2];
   logic [7:0]  m_rb  [2][6];
   int          m_len [2];
   int          m_ptr [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int k);
      longint cyc;
      if (reset) begin
         m_cnt[k] = 0; m_ts[k] = 0; m_run[k] = 0; m_hold[k] = 0;
         m_dl[k] = 0; m_info[k] = 0; m_len[k] = 0; m_ptr[k] = 0;
         return;
      end
      cyc = m_cnt[k];
      if (m_cnt[k] < cmax[k]) m_cnt[k]++;
      if (m_ptr[k] < m_len[k]) begin
         if (rpt_ready) begin
            m_ptr[k]++;
            if (m_ptr[k] == m_len[k]) m_hold[k] = 1;
         end
      end else if (m_hold[k]) begin
         if (clear) begin
            m_hold[k] = 0; m_dl[k] = 0; m_run[k] = 0;
         end
      end else if (enable && block) begin
         m_run[k]++;
         if (m_run[k] == pers[k]) begin
            m_dl[k]   = 1;
            m_info[k] = int'(axis_info) & imask[k];
            m_ts[k]   = cyc;
            m_run[k]  = 0;
            m_rb[k][0] = 8'hDE;
            m_rb[k][1] = 8'(m_info[k]);
            for (int j = 0; j < tsb[k]; j++) m_rb[k][2+j] = 8'(m_ts[k] >> (8 * j));
            m_len[k] = 2 + tsb[k];
            m_ptr[k] = 0;
         end
      end else begin
         m_run[k] = 0;
      end
   endtask

   task automatic compare_all();
      check("a_deadlock", a_deadlock, m_dl[0]);
      check("a_info", a_info, m_info[0]);
      check("a_cycle", a_cycle, m_ts[0]);
      check("a_valid", a_valid, m_ptr[0] < m_len[0]);
      if (m_ptr[0] < m_len[0]) begin
         check("a_data", a_data, m_rb[0][m_ptr[0]]);
         check("a_last", a_last, m_ptr[0] == m_len[0] - 1);
      end else check("a_last_idle", a_last, 0);
      check("b_deadlock", b_deadlock, m_dl[1]);
      check("b_info", b_info, m_info[1]);
      check("b_cycle", b_cycle, m_ts[1]);
      check("b_valid", b_valid, m_ptr[1] < m_len[1]);
      if (m_ptr[1] < m_len[1]) begin
         check("b_data", b_data, m_rb[1][m_ptr[1]]);
         check("b_last", b_last, m_ptr[1] == m_len[1] - 1);
      end else check("b_last_idle", b_last, 0);
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step(0);
      model_step(1);
      @(negedge clock);
      compare_all();
   endtask

   task automatic drain_and_clear();
      int n = 0;
      block = 0; rpt_ready = 1; clear = 0;
      while ((a_valid || b_valid) && n < 40) begin cycle(); n++; end
      check("drain_done", a_valid | b_valid, 0);
      clear = 1; cycle();
      clear = 0; cycle();
   endtask

   task automatic wait_a_valid(input int bound);
      int n = 0;
      while (!a_valid && n < bound) begin cycle(); n++; end
      check("a_valid_seen", a_valid, 1);
   endtask

   logic [7:0] exp_basic [6];
   logic [7:0] got_bytes [6];
   int         nb, hs, acc, run_left;
   logic       last_seen;

   initial begin
      exp_basic = '{8'hDE, 8'h0D, 8'h73, 8'h00, 8'h00, 8'h00};
      reset = 1; enable = 0; block = 0; axis_info = 0; clear = 0; rpt_ready = 1;
      repeat (3) cycle();
      check("rst_a_deadlock", a_deadlock, 0);
      check("rst_a_valid", a_valid, 0);
      check("rst_a_data", a_data, 0);
      check("rst_a_cycle", a_cycle, 0);

      // basic confirm: block from cycle 100, confirmed at edge of cycle 115
      reset = 0; enable = 1;
      repeat (100) cycle();
      block = 1; axis_info = 4'b1101;
      repeat (15) cycle();
      check("basic_early", a_deadlock, 0);
      cycle();
      check("basic_deadlock", a_deadlock, 1);
      check("basic_ts", a_cycle, 115);
      nb = 0; last_seen = 0;
      while (a_valid && nb < 6) begin
         got_bytes[nb] = a_data;
         last_seen = a_last;
         check("basic_last_pos", a_last, nb == 5);
         cycle(); nb++;
      end
      check("basic_nbytes", nb, 6);
      for (int i = 0; i < 6; i++) check("basic_byte", got_bytes[i], exp_basic[i]);
      check("basic_last_seen", last_seen, 1);

      // clear and re-arm with a new timestamp
      drain_and_clear();
      check("clear_deadlock", a_deadlock, 0);
      check("clear_info_held", a_info, 4'b1101);
      block = 1; axis_info = 4'b0110;
      repeat (16) cycle();
      check("rearm_deadlock", a_deadlock, 1);
      check("rearm_info", a_info, 4'b0110);

      // transient filter: 15 high, 1 low, 16 high
      drain_and_clear();
      block = 1; repeat (15) cycle();
      block = 0; cycle();
      block = 1; repeat (15) cycle();
      check("transient_none", a_deadlock, 0);
      cycle();
      check("transient_confirm", a_deadlock, 1);

      // backpressure pattern 1,0,0,1
      drain_and_clear();
      block = 1;
      wait_a_valid(20);
      hs = 0;
      for (int i = 0; i < 60 && a_valid; i++) begin
         rpt_ready = (i % 4 == 0) || (i % 4 == 3);
         if (a_valid && rpt_ready) hs++;
         cycle();
      end
      check("bp_handshakes", hs, 6);

      // reset after two bytes accepted
      drain_and_clear();
      block = 1;
      wait_a_valid(20);
      acc = 0;
      while (acc < 2) begin
         if (a_valid) acc++;
         cycle();
      end
      reset = 1; cycle();
      check("mid_rst_valid", a_valid, 0);
      check("mid_rst_deadlock", a_deadlock, 0);
      check("mid_rst_info", a_info, 0);
      reset = 0;
      repeat (16) cycle();
      check("post_rst_ts", a_cycle, 15);

      // enable gating, then PERSIST 1 single sample
      drain_and_clear();
      enable = 0; block = 1;
      repeat (50) cycle();
      check("gate_a", a_deadlock, 0);
      check("gate_b", b_deadlock, 0);
      enable = 1; axis_info = 4'b0101;
      cycle();
      check("p1_deadlock", b_deadlock, 1);
      check("p1_info", b_info, 3'b101);
      drain_and_clear();

      // randomized run against the model
      run_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (run_left == 0) begin
            block = 1'($urandom_range(0, 1));
            run_left = $urandom_range(1, 24);
            axis_info = 4'($urandom);
         end
         run_left--;
         enable    = ($urandom_range(0, 15) != 0);
         clear     = ($urandom_range(0, 5) == 0);
         rpt_ready = ($urandom_range(0, 2) != 0);
         reset     = ($urandom_range(0, 999) == 0);
         cycle();
      end
      reset = 0; clear = 0;
      drain_and_clear();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/deadlock_report_ctrl.md
# deadlock_report_ctrl

Consumes the per-cycle `block` and `axis_block_info` outputs of the dataflow deadlock monitor. It filters out transient block indications by requiring a persistence window. On a confirmed deadlock it latches the blocked-AXIS information and a cycle timestamp, and serializes a fixed-format byte report over a valid/ready stream to the testbench logger. It sits directly downstream of the monitor in the co-simulation harness and holds a sticky `deadlock` flag until explicitly cleared.

## Interface
- `INFO_W`, default 4: width of `axis_block_info`; must be ≤ 8.
- `PERSIST`, default 16: consecutive cycles `block` must be sampled high to confirm a deadlock; must be ≥ 1.
- `TS_W`, default 32: timestamp width; must be a multiple of 8.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  detection enable; when low, no new confirmation starts.
- `block`  in  1  per-cycle deadlock indication from the monitor.
- `axis_block_info`  in  INFO_W  blocked-AXIS bitmap from the monitor; valid while `block` is high.
- `clear`  in  1  re-arm request; honoured only in HOLD.
- `deadlock`  out  1  sticky confirmed-deadlock flag.
- `deadlock_info`  out  INFO_W  latched info at confirmation.
- `deadlock_cycle`  out  TS_W  latched timestamp at confirmation.
- `rpt_valid`  out  1  report byte valid.
- `rpt_data`  out  8  report byte.
- `rpt_last`  out  1  final byte of the report.
- `rpt_ready`  in  1  sink accepts byte.

## Operation
- **Free-running `cycle_cnt`** (TS_W bits):
  - 0 in the first cycle after reset deasserts; increments every cycle.
  - Saturates at all-ones and never wraps.
- **Persistence counter `pcnt`:**
  - Increments on each cycle sampled with `enable & block`.
  - Any cycle with `block` = 0 or `enable` = 0 resets it to 0 (outside REPORT/HOLD).
- **FSM states:** IDLE, CONFIRM, REPORT, HOLD.
  - **IDLE:** on `enable & block`, set `pcnt` = 1. If PERSIST = 1, confirm immediately; otherwise go to CONFIRM.
  - **CONFIRM:** on `enable & block`, increment `pcnt`. Confirm when `pcnt` reaches PERSIST. On `!block | !enable`, go to IDLE with `pcnt` = 0.
  - **Confirm action** (at the confirming sample edge):
    - `deadlock` ← 1.
    - `deadlock_info` ← `axis_block_info` sampled at that edge.
    - `deadlock_cycle` ← `cycle_cnt` at that edge.
    - Load the byte index with 0 and go to REPORT.
  - **REPORT:** `rpt_valid` = 1. The byte index advances on `rpt_valid & rpt_ready`. When the last byte is accepted, go to HOLD. `block`, `enable` and `clear` are ignored.
  - **HOLD:** `rpt_valid` = 0 and `deadlock` stays 1. On `clear`, go to IDLE: `deadlock` ← 0, `pcnt` ← 0, and the latched info/cycle are held (not zeroed).
- **Report format** (2 + TS_W/8 bytes; 6 bytes at the defaults):
  - Byte 0 = 0xDE.
  - Byte 1 = `deadlock_info` zero-extended to 8 bits.
  - Bytes 2 onward = `deadlock_cycle`, least-significant byte first.
  - `rpt_last` = 1 only on the final byte.
- **Output stability:** `rpt_data` and `rpt_last` are stable while `rpt_valid` is high and `rpt_ready` is low.
- **Reset** dominates everything, including mid-report. After reset, all outputs are 0 and the FSM is in IDLE.

## Timing
- **Confirmation latency:** with `block` sampled high at edges t … t+PERSIST-1, `deadlock` and `rpt_valid` go high after edge t+PERSIST-1. `deadlock_cycle` equals the `cycle_cnt` value at edge t+PERSIST-1.
- **Report throughput:** one byte per cycle when `rpt_ready` is held high, so 6 cycles at the defaults. HOLD is entered after the edge that accepts the last byte.
- **Clear to re-arm:** `clear` high at a HOLD edge makes `deadlock` 0 in the next cycle. A new confirmation may start at the following edge.
- **Gap of one cycle:** a single low cycle of `block` restarts the count. The PERSIST window must then be satisfied again from 1.
- **Simultaneous `clear` and `block` in HOLD:** `clear` is processed, the FSM enters IDLE, and that cycle's `block` is not counted.

## Test plan
- **Basic confirm:** PERSIST = 16, `block` = 1 and `axis_block_info` = 4'b1101 from cycle 100 onward. Required: `deadlock` = 1 after the edge at cycle 115; report bytes DE,0D,73,00,00,00 with `rpt_ready` = 1; `rpt_last` on byte 6.
- **Transient filter:** `block` high for 15 cycles, low 1 cycle, high for 16 cycles. Required: `deadlock` rises only at the end of the second run; the timestamp is that of the 16th sample of the second run.
- **Backpressure:** `rpt_ready` toggles 1,0,0,1 repeatedly. Required: every byte is held stable while stalled; exactly 6 handshakes; no byte is skipped or duplicated.
- **Clear and re-arm:** confirm, drain the report, hold `clear` for 1 cycle. Required: `deadlock` = 0 next cycle; a second persistent `block` run produces a second report carrying the new timestamp.
- **Reset mid-report:** assert `reset` after byte 2 is accepted. Required: `rpt_valid`, `deadlock` and `deadlock_info` are 0 the next cycle; `cycle_cnt` restarts at 0.
- **Enable gating and PERSIST = 1:** with `enable` = 0, `block` = 1 for 50 cycles gives no deadlock. With PERSIST = 1, a single sampled `block` gives `deadlock` in the next cycle.
